// File: rtl/inst_package.sv
// Shared instruction constants for the fetch slice: the Nop encoding and a
// helper that builds an all-Nop bundle of up to MAX_ISSUE_W lanes.
package inst_package;

  localparam logic [5:0]  Nop         = 6'h2a;
  localparam logic [31:0] NOP_INST    = {Nop, 26'b0};
  localparam int          MAX_ISSUE_W = 8;

  function automatic logic [MAX_ISSUE_W*32-1:0] nop_bundle(input int issue_w);
    logic [MAX_ISSUE_W*32-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_ISSUE_W; i++) begin
      if (i < issue_w) r[i*32 +: 32] = NOP_INST;
    end
    return r;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO decoupling returned bundles from decode; extra pointer bit
// distinguishes full from empty.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign count   = wr_ptr - rd_ptr;
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset; stale entries are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/fetch_buffered.sv
// Fetch stage: credit-limited requests to a fixed-latency memory, a request
// pipeline tracking in-flight indices, and a bundle queue in front of decode.
module fetch_buffered
  import inst_package::*;
#(
  parameter int ISSUE_W = 2,
  parameter int INST_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int MEM_LAT = 1,
  parameter int QDEPTH  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic [ADDR_W-1:0]           imem_addr,
  output logic                        imem_en,
  input  logic [ISSUE_W*INST_W-1:0]   imem_rdata,
  input  logic                        redirect_valid,
  input  logic [ADDR_W-1:0]           redirect_pc,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [ADDR_W-1:0]           out_pc,
  output logic [ISSUE_W*INST_W-1:0]   out_inst
);

  localparam int BW = ISSUE_W * INST_W;
  localparam int CW = $clog2(QDEPTH) + 1;
  localparam logic [BW-1:0] NOP_BUNDLE = BW'(nop_bundle(ISSUE_W));

  logic [ADDR_W-1:0]    pc;
  logic [MEM_LAT-1:0]   stage_valid;
  logic [ADDR_W-1:0]    stage_pc [MEM_LAT];
  logic [31:0]          inflight;
  logic                 credit_ok;
  logic                 redir;
  logic                 q_push;
  logic                 q_pop;
  logic                 q_empty;
  logic [CW-1:0]        q_count;
  logic [ADDR_W+BW-1:0] q_head;

  always_comb begin
    inflight = '0;
    for (int k = 0; k < MEM_LAT; k++) inflight = inflight + 32'(stage_valid[k]);
  end

  // Credit ignores a same-cycle pop, so the queue can never be overrun.
  assign credit_ok = (32'(q_count) + inflight) < 32'(QDEPTH);
  assign redir     = redirect_valid & ~rst;
  assign imem_en   = ~rst & (redirect_valid | credit_ok);
  assign imem_addr = redir ? redirect_pc : pc;

  assign q_push    = stage_valid[MEM_LAT-1] & ~redir;
  assign out_valid = ~rst & ~q_empty;
  assign q_pop     = out_valid & out_ready;
  assign out_pc    = out_valid ? q_head[BW +: ADDR_W] : '0;
  assign out_inst  = out_valid ? q_head[BW-1:0] : NOP_BUNDLE;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= '0;
      stage_valid <= '0;
      for (int k = 0; k < MEM_LAT; k++) stage_pc[k] <= '0;
    end else begin
      if (imem_en) pc <= imem_addr + ADDR_W'(1);
      stage_valid[0] <= imem_en;
      stage_pc[0]    <= imem_addr;
      // A redirect drops every older request still travelling to memory.
      for (int k = 1; k < MEM_LAT; k++) begin
        stage_valid[k] <= redir ? 1'b0 : stage_valid[k-1];
        stage_pc[k]    <= stage_pc[k-1];
      end
    end
  end

  fetch_queue #(
    .DEPTH (QDEPTH),
    .WIDTH (ADDR_W + BW)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (redir),
    .push      (q_push),
    .push_data ({stage_pc[MEM_LAT-1], imem_rdata}),
    .pop       (q_pop),
    .head      (q_head),
    .count     (q_count),
    .empty     (q_empty)
  );

endmodule

// File: tb/tb_fetch_buffered.sv
// Directed bench for fetch_buffered: a vector table on the default build plus
// hand sequences for MEM_LAT=3/ISSUE_W=4 and 8-bit index wrap.
module tb_fetch_buffered;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] NOP_WORD = 32'ha800_0000;

  // Memory contents: lane i of bundle a is {i+1, a[23:0]}.
  function automatic logic [255:0] make_bundle(input logic [31:0] a);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = {8'(i + 1), a[23:0]};
    return r;
  endfunction

  // Instance A: default parameters.
  logic [31:0] a_addr, a_rpc, a_out_pc, a_mem_q;
  logic        a_en, a_rv, a_ready, a_valid;
  logic [63:0] a_rdata, a_inst;
  always @(posedge clk) a_mem_q <= a_addr;
  assign a_rdata = 64'(make_bundle(a_mem_q));

  fetch_buffered u_dut_a (
    .clk(clk), .rst(rst), .imem_addr(a_addr), .imem_en(a_en), .imem_rdata(a_rdata),
    .redirect_valid(a_rv), .redirect_pc(a_rpc), .out_valid(a_valid), .out_ready(a_ready),
    .out_pc(a_out_pc), .out_inst(a_inst)
  );

  // Instance B: MEM_LAT=3, ISSUE_W=4.
  logic [31:0]  b_addr, b_out_pc;
  logic [31:0]  b_mem_q [3];
  logic         b_en, b_valid;
  logic [127:0] b_rdata, b_inst;
  always @(posedge clk) begin
    b_mem_q[0] <= b_addr;
    b_mem_q[1] <= b_mem_q[0];
    b_mem_q[2] <= b_mem_q[1];
  end
  assign b_rdata = 128'(make_bundle(b_mem_q[2]));

  fetch_buffered #(.ISSUE_W(4), .MEM_LAT(3), .QDEPTH(4)) u_dut_b (
    .clk(clk), .rst(rst), .imem_addr(b_addr), .imem_en(b_en), .imem_rdata(b_rdata),
    .redirect_valid(1'b0), .redirect_pc(32'h0), .out_valid(b_valid), .out_ready(1'b1),
    .out_pc(b_out_pc), .out_inst(b_inst)
  );

  // Instance C: ADDR_W=8.
  logic [7:0]  c_addr, c_rpc, c_out_pc, c_mem_q;
  logic        c_en, c_rv, c_valid;
  logic [63:0] c_rdata, c_inst;
  always @(posedge clk) c_mem_q <= c_addr;
  assign c_rdata = 64'(make_bundle(32'(c_mem_q)));

  fetch_buffered #(.ADDR_W(8)) u_dut_c (
    .clk(clk), .rst(rst), .imem_addr(c_addr), .imem_en(c_en), .imem_rdata(c_rdata),
    .redirect_valid(c_rv), .redirect_pc(c_rpc), .out_valid(c_valid), .out_ready(1'b1),
    .out_pc(c_out_pc), .out_inst(c_inst)
  );

  typedef struct {
    logic        rst;
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        ev;
    logic [31:0] epc;
    logic        een;
    logic [31:0] eaddr;
  } vec_t;

  localparam int NV = 27;
  vec_t vecs [NV];

  task automatic check_output(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    @(negedge clk);
    rst     = v.rst;
    a_rv    = v.rv;
    a_rpc   = v.rpc;
    a_ready = v.rdy;
    #1;
  endtask

  task automatic reset_all();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  initial begin
    logic [31:0] next_exp;
    logic [7:0]  c_exp;
    int          c_seen;

    rst = 1'b1; a_rv = 1'b0; a_rpc = '0; a_ready = 1'b1;
    c_rv = 1'b0; c_rpc = '0;

    //          rst   rv    rpc        rdy     ev    epc        en    addr
    vecs[0]  = '{1'b1, 1'b0, 32'h0,    1'b1,   1'b0, 32'h0,     1'b0, 32'h0};
    vecs[1]  = '{1'b1, 1'b1, 32'h55,   1'b1,   1'b0, 32'h0,     1'b0, 32'h0};
    vecs[2]  = '{1'b0, 1'b0, 32'h0,    1'b1,   1'b0, 32'h0,     1'b1, 32'h0};
    vecs[3]  = '{1'b0, 1'b0, 32'h0,    1'b1,   1'b0, 32'h0,     1'b1, 32'h1};
    vecs[4]  = '{1'b0, 1'b0, 32'h0,    1'b1,   1'b1, 32'h0,     1'b1, 32'h2};
    vecs[5]  = '{1'b0, 1'b0, 32'h0,    1'b1,   1'b1, 32'h1,     1'b1, 32'h3};
    vecs[6]  = '{1'b0, 1'b0, 32'h0,    1'b0,   1'b1, 32'h2,     1'b1, 32'h4};
    vecs[7]  = '{1'b0, 1'b0, 32'h0,    1'b0,   1'b1, 32'h2,     1'b1, 32'h5};
    vecs[8]  = '{1'b0, 1'b0, 32'h0,    1'b0,   1'b1, 32'h2,     1'b0, 32'h6};
    vecs[9]  = '{1'b0, 1'b0, 32'h0,    1'b0,   1'b1, 32'h2,     1'b0, 32'h6};
    vecs[10] = '{1'b0, 1'b0, 32'h0,    1'b0,   1'b1, 32'h2,     1'b0, 32'h6};
    vecs[11] = '{1'b0, 1'b0, 32'h0,    1'b1,   1'b1, 32'h2,     1'b0, 32'h6};
    vecs[12] = '{1'b0, 1'b0, 32'h0,    1'b1,   1'b1, 32'h3,     1'b1, 32'h6};
    vecs[13] = '{1'b0, 1'b0, 32'h0,    1'b1,   1'b1, 32'h4,     1'b1, 32'h7};
    vecs[14] = '{1'b0, 1'b0, 32'h0,    1'b0,   1'b1, 32'h5,     1'b1, 32'h8};
    vecs[15] = '{1'b0, 1'b1, 32'h100,  1'b1,   1'b1, 32'h5,     1'b1, 32'h100};
    vecs[16] = '{1'b0, 1'b0, 32'h0,    1'b1,   1'b0, 32'h0,     1'b1, 32'h101};
    vecs[17] = '{1'b0, 1'b0, 32'h0,    1'b1,   1'b1, 32'h100,   1'b1, 32'h102};
    vecs[18] = '{1'b0, 1'b1, 32'h40,   1'b1,   1'b1, 32'h101,   1'b1, 32'h40};
    vecs[19] = '{1'b0, 1'b1, 32'h80,   1'b1,   1'b0, 32'h0,     1'b1, 32'h80};
    vecs[20] = '{1'b0, 1'b0, 32'h0,    1'b1,   1'b0, 32'h0,     1'b1, 32'h81};
    vecs[21] = '{1'b0, 1'b0, 32'h0,    1'b1,   1'b1, 32'h80,    1'b1, 32'h82};
    vecs[22] = '{1'b0, 1'b0, 32'h0,    1'b1,   1'b1, 32'h81,    1'b1, 32'h83};
    vecs[23] = '{1'b1, 1'b0, 32'h0,    1'b1,   1'b0, 32'h0,     1'b0, 32'h84};
    vecs[24] = '{1'b0, 1'b0, 32'h0,    1'b1,   1'b0, 32'h0,     1'b1, 32'h0};
    vecs[25] = '{1'b0, 1'b0, 32'h0,    1'b1,   1'b0, 32'h0,     1'b1, 32'h1};
    vecs[26] = '{1'b0, 1'b0, 32'h0,    1'b1,   1'b1, 32'h0,     1'b1, 32'h2};

    repeat (2) @(posedge clk);

    for (int i = 0; i < NV; i++) begin
      apply_stimulus(vecs[i]);
      check_output($sformatf("a_valid[%0d]", i), 256'(a_valid), 256'(vecs[i].ev));
      check_output($sformatf("a_out_pc[%0d]", i), 256'(a_out_pc), 256'(vecs[i].epc));
      check_output($sformatf("a_inst[%0d]", i), 256'(a_inst),
                   vecs[i].ev ? 256'(64'(make_bundle(vecs[i].epc))) : 256'({2{NOP_WORD}}));
      check_output($sformatf("a_en[%0d]", i), 256'(a_en), 256'(vecs[i].een));
      check_output($sformatf("a_addr[%0d]", i), 256'(a_addr), 256'(vecs[i].eaddr));
    end

    // MEM_LAT=3 build: first bundle in cycle 4, then strictly in order.
    reset_all();
    check_output("b_en_c0", 256'(b_en), 256'(1'b1));
    check_output("b_addr_c0", 256'(b_addr), 256'(32'h0));
    next_exp = 32'h0;
    for (int c = 0; c < 24; c++) begin
      if (c > 0) begin
        @(negedge clk);
        #1;
      end
      if (c < 4) begin
        check_output($sformatf("b_valid_c%0d", c), 256'(b_valid), 256'(1'b0));
        check_output($sformatf("b_inst_c%0d", c), 256'(b_inst), 256'({4{NOP_WORD}}));
      end else if (c == 4) begin
        check_output("b_valid_c4", 256'(b_valid), 256'(1'b1));
      end
      if (b_valid) begin
        check_output($sformatf("b_out_pc_c%0d", c), 256'(b_out_pc), 256'(next_exp));
        check_output($sformatf("b_inst_c%0d", c), 256'(b_inst), 256'(128'(make_bundle(next_exp))));
        next_exp = next_exp + 32'h1;
      end
    end
    check_output("b_delivered_min", 256'(next_exp >= 32'd14), 256'(1'b1));

    // 8-bit index: redirect to 0xFF must wrap to 0x00 next.
    reset_all();
    repeat (3) @(negedge clk);
    c_rv  = 1'b1;
    c_rpc = 8'hff;
    #1;
    check_output("c_redir_addr", 256'(c_addr), 256'(8'hff));
    check_output("c_redir_en", 256'(c_en), 256'(1'b1));
    @(negedge clk);
    c_rv = 1'b0;
    #1;
    check_output("c_valid_r1", 256'(c_valid), 256'(1'b0));
    c_exp  = 8'hff;
    c_seen = 0;
    for (int c = 0; c < 8 && c_seen < 3; c++) begin
      @(negedge clk);
      #1;
      if (c_valid) begin
        check_output($sformatf("c_out_pc_%0d", c_seen), 256'(c_out_pc), 256'(c_exp));
        check_output($sformatf("c_inst_%0d", c_seen), 256'(c_inst), 256'(64'(make_bundle(32'(c_exp)))));
        c_exp  = c_exp + 8'h1;
        c_seen = c_seen + 1;
      end
    end
    check_output("c_seen", 256'(c_seen), 256'(3));

    // Reset mid-stream: nothing survives, restart at index 0.
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_output("c_rst_valid", 256'(c_valid), 256'(1'b0));
    check_output("c_rst_en", 256'(c_en), 256'(1'b0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_output("c_after_rst_valid", 256'(c_valid), 256'(1'b0));
    check_output("c_after_rst_addr", 256'(c_addr), 256'(8'h00));
    @(negedge clk);
    #1;
    check_output("c_after_rst_valid2", 256'(c_valid), 256'(1'b0));
    @(negedge clk);
    #1;
    check_output("c_after_rst_valid3", 256'(c_valid), 256'(1'b1));
    check_output("c_after_rst_pc", 256'(c_out_pc), 256'(8'h00));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
